// File: rtl/counter_pkg.sv
// Shared types and width helpers for the up/down counter family.
package counter_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   // Guard bit so sums and differences never truncate before the range compare.
   localparam int unsigned EXT_BITS = 1;

   function automatic int unsigned ext_width(input int unsigned w);
      return w + EXT_BITS;
   endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle for updown_counter_mod; the controller is master, the counter is slave.
interface updown_counter_mod_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic             up;
   logic             down;
   logic [WIDTH-1:0] step;
   logic             sat_mode;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic             at_max;
   logic             at_min;
   logic             ovf;
   logic             unf;

   modport master (
      output en, up, down, step, sat_mode, load, load_value,
      input  count, at_max, at_min, ovf, unf
   );

   modport slave (
      input  en, up, down, step, sat_mode, load, load_value,
      output count, at_max, at_min, ovf, unf
   );
endinterface

// File: rtl/count_step_alu.sv
// Next-count arithmetic for one step, with wrap/saturate handling and crossing events.
// Latency: combinational. Backpressure: none.
module count_step_alu
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] s,
   input  logic             dir_up,
   input  cnt_mode_e        mode,
   input  logic [WIDTH-1:0] max_value,
   output logic [WIDTH-1:0] next_count,
   output logic             ovf,
   output logic             unf
);
   localparam int unsigned EW = ext_width(WIDTH);

   logic [EW-1:0] count_e;
   logic [EW-1:0] s_e;
   logic [EW-1:0] max_e;
   logic [EW-1:0] modulus;
   logic [EW-1:0] sum;
   logic [EW-1:0] wrap_up;
   logic [EW-1:0] wrap_dn;
   logic [EW-1:0] diff;

   always_comb begin
      count_e = {1'b0, count};
      s_e     = {1'b0, s};
      max_e   = {1'b0, max_value};
      modulus = max_e + EW'(1);
      sum     = count_e + s_e;
      wrap_up = sum - modulus;
      wrap_dn = count_e + modulus - s_e;
      diff    = count_e - s_e;

      next_count = count;
      ovf        = 1'b0;
      unf        = 1'b0;

      if (dir_up) begin
         if (sum <= max_e) begin
            next_count = sum[WIDTH-1:0];
         end else if (mode == CNT_WRAP) begin
            next_count = wrap_up[WIDTH-1:0];
            ovf        = 1'b1;
         end else begin
            next_count = max_value;
            ovf        = (count != max_value);
         end
      end else begin
         if (count_e >= s_e) begin
            next_count = diff[WIDTH-1:0];
         end else if (mode == CNT_WRAP) begin
            next_count = wrap_dn[WIDTH-1:0];
            unf        = 1'b1;
         end else begin
            next_count = '0;
            unf        = (count != '0);
         end
      end
   end
endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, runtime step, load and wrap/saturate mode.
// Latency: 1 cycle input to count/ovf/unf. Backpressure: none, accepts a command every cycle.
module updown_counter_mod
   import counter_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input logic                clk,
   input logic                rst,
   updown_counter_mod_if.slave bus
);
   logic [WIDTH-1:0] count_q;
   logic             ovf_q;
   logic             unf_q;

   logic [WIDTH-1:0] s_eff;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] alu_next;
   logic             alu_ovf;
   logic             alu_unf;
   logic             step_act;
   cnt_mode_e        mode;

   always_comb begin
      s_eff        = (bus.step > MAX_VALUE) ? MAX_VALUE : bus.step;
      load_clamped = (bus.load_value > MAX_VALUE) ? MAX_VALUE : bus.load_value;
      step_act     = bus.en && (bus.up ^ bus.down);
      mode         = bus.sat_mode ? CNT_SAT : CNT_WRAP;
   end

   count_step_alu #(.WIDTH(WIDTH)) u_alu (
      .count      (count_q),
      .s          (s_eff),
      .dir_up     (bus.up),
      .mode       (mode),
      .max_value  (MAX_VALUE),
      .next_count (alu_next),
      .ovf        (alu_ovf),
      .unf        (alu_unf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= RESET_VALUE;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (bus.load) begin
         count_q <= load_clamped;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (step_act) begin
         count_q <= alu_next;
         ovf_q   <= alu_ovf;
         unf_q   <= alu_unf;
      end else begin
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end
   end

   // Terminal flags decode the register only, so they never see an input directly.
   assign bus.count  = count_q;
   assign bus.ovf    = ovf_q;
   assign bus.unf    = unf_q;
   assign bus.at_max = (count_q == MAX_VALUE);
   assign bus.at_min = (count_q == '0);
endmodule
